wb_hazard_tracker: RTL and testbench
====================================

Name: wb_hazard_tracker

Overview:
Producer end of the operand-forwarding path. Registers the EX-stage result and destination each cycle and drives write_reg / rn1_ex / write_r0 and the matching data to the forwarding muxes and register file. Also sequences fixed-latency multi-cycle operations (mul/div, which write both Rd and R0). While such an operation runs it holds a pipeline stall and emits bubbles.

Parameters:
REG_NUM_WIDTH, 4, register-number width
DATA_WIDTH, 16, register data width
MC_LATENCY, 4, cycles from multi-cycle issue to result valid (legal range 2..15)
CNT_WIDTH, 4, width of the latency counter

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous squash of the pending and in-flight write
ex_valid  in  1  EX holds a real instruction this cycle
ex_rd  in  REG_NUM_WIDTH  destination register
ex_wr_en  in  1  instruction writes ex_rd
ex_wr_r0  in  1  instruction writes R0 (second result)
ex_multi  in  1  instruction is multi-cycle
ex_result  in  DATA_WIDTH  single-cycle Rd result
ex_r0_result  in  DATA_WIDTH  single-cycle R0 result
mc_result  in  DATA_WIDTH  multi-cycle unit Rd result, valid when the count expires
mc_r0_result  in  DATA_WIDTH  multi-cycle unit R0 result
stall  out  1  freeze IF/ID/EX
write_reg  out  1  WB writes rn1_ex this cycle
rn1_ex  out  REG_NUM_WIDTH  WB destination register
write_r0  out  1  WB writes R0 this cycle
wb_data  out  DATA_WIDTH  data for rn1_ex
wb_r0_data  out  DATA_WIDTH  data for R0

Behaviour:
- Reset (async, rst_n=0): state=IDLE, count=0. write_reg, write_r0 and stall are 0. rn1_ex, wb_data and wb_r0_data are 0. Captured rd and enables are cleared.
- All outputs except stall are registered. stall is decoded combinationally from state only, never from inputs.
- IDLE, ex_valid=1, ex_multi=0:
  - Next edge loads write_reg=ex_wr_en, rn1_ex=ex_rd, write_r0=ex_wr_r0, wb_data=ex_result, wb_r0_data=ex_r0_result.
  - Latency is 1 cycle. Back-to-back issue is allowed every cycle.
- IDLE, ex_valid=0: next edge loads write_reg=0 and write_r0=0. rn1_ex and data hold.
- IDLE, ex_valid=1, ex_multi=1:
  - Capture ex_rd, ex_wr_en and ex_wr_r0.
  - count=MC_LATENCY-1; state=BUSY.
  - Registered outputs become a bubble (write_reg=0, write_r0=0).
- BUSY:
  - stall=1. All ex_* inputs are ignored.
  - count decrements each edge. Outputs stay a bubble.
  - When count==1, the next edge loads write_reg/write_r0 from the captured enables, rn1_ex from the captured rd, and wb_data/wb_r0_data from mc_result/mc_r0_result. state=IDLE and stall drops.
  - Total stall is MC_LATENCY-1 cycles. The results appear at WB MC_LATENCY cycles after the issue edge.
- flush (synchronous, highest priority after reset):
  - Next edge forces write_reg=0, write_r0=0, state=IDLE, count=0.
  - This holds regardless of ex_* inputs or a BUSY count (including count==1).
- Register R0 as ex_rd with ex_wr_en=1 is legal. It is reported only via write_reg/rn1_ex, and write_r0 follows ex_wr_r0 independently.
- Asserting rst_n mid-BUSY drops stall immediately (asynchronously). The in-flight result is discarded.
- Invariant: while stall=1, write_reg=0 and write_r0=0.

Decomposition:
- Shared package cpu_pkg holds:
  - the state encoding (IDLE=1'b0, BUSY=1'b1)
  - REG_NUM_WIDTH and DATA_WIDTH constants
  - the R0 index constant
- One natural sub-module: mc_latency_counter. It is a loadable down-counter with load, dec and a zero-next flag, instantiated once.
- The remaining logic stays flat.

Test Plan:
- Reset: rst_n=0 mid-cycle -> stall, write_reg and write_r0 are 0 immediately. rn1_ex=0, wb_data=0.
- Single-cycle: ex_valid=1, ex_rd=5, ex_wr_en=1, ex_result=16'h1234 -> next edge write_reg=1, rn1_ex=5, wb_data=16'h1234, write_r0=0.
- Multi-cycle (MC_LATENCY=4): issue ex_multi with rd=3, wr_en=1, wr_r0=1; mc_result=16'h00AA, mc_r0_result=16'h0001 at the final edge -> stall=1 for 3 cycles, bubbles during BUSY. On edge 4: write_reg=1, rn1_ex=3, wb_data=16'h00AA, write_r0=1, wb_r0_data=16'h0001.
- Flush mid-BUSY: flush=1 when count==1 -> no write is emitted. State returns to IDLE and the next single-cycle op issues normally.
- Back-to-back: single-cycle ops to R2, R7 and R0 on consecutive cycles -> rn1_ex sequence is 2, 7, 0 with write_reg=1 each cycle. No stall.
- Async reset mid-BUSY: rst_n=0 at count==2 -> stall=0 without waiting for a clock edge, and no write appears afterward.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: sequencer state encoding, datapath widths and
// the index of the implicit second-result register R0.
package cpu_pkg;

    localparam int REG_NUM_WIDTH = 4;
    localparam int DATA_WIDTH    = 16;

    localparam logic [REG_NUM_WIDTH-1:0] R0_INDEX = '0;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

endpackage

// File: rtl/mc_latency_counter.sv
// Loadable down-counter that times fixed-latency multi-cycle operations.
// zero_next flags the last busy cycle so the caller can retire on that edge.
module mc_latency_counter #(
    parameter int CNT_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 load,
    input  logic [CNT_WIDTH-1:0] load_value,
    input  logic                 dec,
    output logic [CNT_WIDTH-1:0] count,
    output logic                 zero_next
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero_next = (count == CNT_WIDTH'(1));

endmodule

// File: rtl/wb_hazard_tracker.sv
// Writeback-side producer for operand forwarding: registers the EX result and
// destination, and sequences fixed-latency mul/div ops behind a pipeline stall.
module wb_hazard_tracker
    import cpu_pkg::*;
#(
    parameter int REG_NUM_WIDTH = cpu_pkg::REG_NUM_WIDTH,
    parameter int DATA_WIDTH    = cpu_pkg::DATA_WIDTH,
    parameter int MC_LATENCY    = 4,
    parameter int CNT_WIDTH     = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     ex_valid,
    input  logic [REG_NUM_WIDTH-1:0] ex_rd,
    input  logic                     ex_wr_en,
    input  logic                     ex_wr_r0,
    input  logic                     ex_multi,
    input  logic [DATA_WIDTH-1:0]    ex_result,
    input  logic [DATA_WIDTH-1:0]    ex_r0_result,
    input  logic [DATA_WIDTH-1:0]    mc_result,
    input  logic [DATA_WIDTH-1:0]    mc_r0_result,
    output logic                     stall,
    output logic                     write_reg,
    output logic [REG_NUM_WIDTH-1:0] rn1_ex,
    output logic                     write_r0,
    output logic [DATA_WIDTH-1:0]    wb_data,
    output logic [DATA_WIDTH-1:0]    wb_r0_data
);

    logic [0:0]               state;
    logic [REG_NUM_WIDTH-1:0] cap_rd;
    logic                     cap_wr_en;
    logic                     cap_wr_r0;
    logic [CNT_WIDTH-1:0]     count;
    logic                     zero_next;
    logic                     issue_multi;
    logic                     busy;

    assign busy        = (state == ST_BUSY);
    assign issue_multi = !flush && !busy && ex_valid && ex_multi;

    // Stall depends on state alone so it can never form a path from EX inputs.
    assign stall = busy;

    mc_latency_counter #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_mc_counter (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (flush),
        .load       (issue_multi),
        .load_value (CNT_WIDTH'(MC_LATENCY - 1)),
        .dec        (!flush && busy),
        .count      (count),
        .zero_next  (zero_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            cap_rd     <= '0;
            cap_wr_en  <= 1'b0;
            cap_wr_r0  <= 1'b0;
            write_reg  <= 1'b0;
            write_r0   <= 1'b0;
            rn1_ex     <= '0;
            wb_data    <= '0;
            wb_r0_data <= '0;
        end else if (flush) begin
            state     <= ST_IDLE;
            write_reg <= 1'b0;
            write_r0  <= 1'b0;
        end else if (!busy) begin
            if (ex_valid && !ex_multi) begin
                write_reg  <= ex_wr_en;
                write_r0   <= ex_wr_r0;
                rn1_ex     <= ex_rd;
                wb_data    <= ex_result;
                wb_r0_data <= ex_r0_result;
            end else begin
                write_reg <= 1'b0;
                write_r0  <= 1'b0;
                if (ex_valid) begin
                    state     <= ST_BUSY;
                    cap_rd    <= ex_rd;
                    cap_wr_en <= ex_wr_en;
                    cap_wr_r0 <= ex_wr_r0;
                end
            end
        end else if (zero_next) begin
            // Final busy edge: the multi-cycle unit's results are valid now.
            state      <= ST_IDLE;
            write_reg  <= cap_wr_en;
            write_r0   <= cap_wr_r0;
            rn1_ex     <= cap_rd;
            wb_data    <= mc_result;
            wb_r0_data <= mc_r0_result;
        end else begin
            write_reg <= 1'b0;
            write_r0  <= 1'b0;
        end
    end

    // count is only observed through zero_next outside the counter.
    logic unused_count;
    assign unused_count = ^count;

endmodule

// File: tb/tb_wb_hazard_tracker.sv
// Directed bench for wb_hazard_tracker: single-cycle writes, multi-cycle
// sequencing, flush and asynchronous reset, with hand-computed expectations.
module tb_wb_hazard_tracker;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        ex_valid;
    logic [3:0]  ex_rd;
    logic        ex_wr_en;
    logic        ex_wr_r0;
    logic        ex_multi;
    logic [15:0] ex_result;
    logic [15:0] ex_r0_result;
    logic [15:0] mc_result;
    logic [15:0] mc_r0_result;
    logic        stall;
    logic        write_reg;
    logic [3:0]  rn1_ex;
    logic        write_r0;
    logic [15:0] wb_data;
    logic [15:0] wb_r0_data;

    int checkCount = 0;
    int errorCount = 0;

    wb_hazard_tracker #(
        .REG_NUM_WIDTH (4),
        .DATA_WIDTH    (16),
        .MC_LATENCY    (4),
        .CNT_WIDTH     (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .ex_valid     (ex_valid),
        .ex_rd        (ex_rd),
        .ex_wr_en     (ex_wr_en),
        .ex_wr_r0     (ex_wr_r0),
        .ex_multi     (ex_multi),
        .ex_result    (ex_result),
        .ex_r0_result (ex_r0_result),
        .mc_result    (mc_result),
        .mc_r0_result (mc_r0_result),
        .stall        (stall),
        .write_reg    (write_reg),
        .rn1_ex       (rn1_ex),
        .write_r0     (write_r0),
        .wb_data      (wb_data),
        .wb_r0_data   (wb_r0_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [3:0] rd, input logic wr_en,
                                 input logic wr_r0, input logic multi,
                                 input logic [15:0] result, input logic [15:0] r0_result);
        ex_valid     = valid;
        ex_rd        = rd;
        ex_wr_en     = wr_en;
        ex_wr_r0     = wr_r0;
        ex_multi     = multi;
        ex_result    = result;
        ex_r0_result = r0_result;
    endtask

    // Advance one rising edge and settle just past it before sampling.
    task automatic stepClock();
        @(posedge clk);
        #1;
    endtask

    task automatic checkBubble(input string tag);
        checkOutput({tag, ".write_reg"}, 32'(write_reg), 32'd0);
        checkOutput({tag, ".write_r0"}, 32'(write_r0), 32'd0);
    endtask

    initial begin
        rst_n        = 1'b1;
        flush        = 1'b0;
        mc_result    = 16'h0000;
        mc_r0_result = 16'h0000;
        applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);

        // Reset asserted mid-cycle, checked before any clock edge.
        #2 rst_n = 1'b0;
        #1;
        checkOutput("reset.stall", 32'(stall), 32'd0);
        checkBubble("reset");
        checkOutput("reset.rn1_ex", 32'(rn1_ex), 32'd0);
        checkOutput("reset.wb_data", 32'(wb_data), 32'd0);
        checkOutput("reset.wb_r0_data", 32'(wb_r0_data), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single-cycle write.
        applyStimulus(1'b1, 4'd5, 1'b1, 1'b0, 1'b0, 16'h1234, 16'h5555);
        stepClock();
        checkOutput("single.write_reg", 32'(write_reg), 32'd1);
        checkOutput("single.rn1_ex", 32'(rn1_ex), 32'd5);
        checkOutput("single.wb_data", 32'(wb_data), 32'h1234);
        checkOutput("single.write_r0", 32'(write_r0), 32'd0);
        checkOutput("single.stall", 32'(stall), 32'd0);

        // Idle cycle: write enables drop, destination and data hold.
        applyStimulus(1'b0, 4'd9, 1'b1, 1'b1, 1'b0, 16'hDEAD, 16'hBEEF);
        stepClock();
        checkBubble("idle");
        checkOutput("idle.rn1_ex_hold", 32'(rn1_ex), 32'd5);
        checkOutput("idle.wb_data_hold", 32'(wb_data), 32'h1234);

        // Multi-cycle op: 3 stall cycles, result on the 4th edge.
        applyStimulus(1'b1, 4'd3, 1'b1, 1'b1, 1'b1, 16'hFFFF, 16'hFFFF);
        mc_result    = 16'h00AA;
        mc_r0_result = 16'h0001;
        for (int i = 0; i < 3; i++) begin
            stepClock();
            checkOutput($sformatf("multi.stall%0d", i), 32'(stall), 32'd1);
            checkBubble($sformatf("multi.bubble%0d", i));
            // Inputs during BUSY must be ignored.
            applyStimulus(1'b1, 4'd9, 1'b1, 1'b1, 1'b0, 16'hDEAD, 16'hBEEF);
        end
        stepClock();
        checkOutput("multi.stall_drop", 32'(stall), 32'd0);
        checkOutput("multi.write_reg", 32'(write_reg), 32'd1);
        checkOutput("multi.rn1_ex", 32'(rn1_ex), 32'd3);
        checkOutput("multi.wb_data", 32'(wb_data), 32'h00AA);
        checkOutput("multi.write_r0", 32'(write_r0), 32'd1);
        checkOutput("multi.wb_r0_data", 32'(wb_r0_data), 32'h0001);
        applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        stepClock();
        checkBubble("multi.after");

        // Flush on the last BUSY cycle (count==1) squashes the write.
        applyStimulus(1'b1, 4'd4, 1'b1, 1'b1, 1'b1, 16'h0000, 16'h0000);
        mc_result    = 16'h7777;
        mc_r0_result = 16'h8888;
        stepClock();
        applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        stepClock();
        stepClock();
        checkOutput("flush.pre_stall", 32'(stall), 32'd1);
        flush = 1'b1;
        stepClock();
        flush = 1'b0;
        checkOutput("flush.stall", 32'(stall), 32'd0);
        checkBubble("flush");
        checkOutput("flush.rn1_ex_hold", 32'(rn1_ex), 32'd3);
        applyStimulus(1'b1, 4'd6, 1'b1, 1'b0, 1'b0, 16'hBEEF, 16'h0000);
        stepClock();
        checkOutput("flush.next_write_reg", 32'(write_reg), 32'd1);
        checkOutput("flush.next_rn1_ex", 32'(rn1_ex), 32'd6);
        checkOutput("flush.next_wb_data", 32'(wb_data), 32'hBEEF);

        // Flush beats a valid single-cycle op in IDLE.
        applyStimulus(1'b1, 4'd1, 1'b1, 1'b1, 1'b0, 16'h4321, 16'h0000);
        flush = 1'b1;
        stepClock();
        flush = 1'b0;
        checkBubble("flush_idle");

        // Back-to-back single-cycle ops to R2, R7, R0.
        applyStimulus(1'b1, 4'd2, 1'b1, 1'b0, 1'b0, 16'h0202, 16'h0000);
        stepClock();
        checkOutput("b2b.r2.write_reg", 32'(write_reg), 32'd1);
        checkOutput("b2b.r2.rn1_ex", 32'(rn1_ex), 32'd2);
        checkOutput("b2b.r2.wb_data", 32'(wb_data), 32'h0202);
        applyStimulus(1'b1, 4'd7, 1'b1, 1'b1, 1'b0, 16'h0707, 16'h7070);
        stepClock();
        checkOutput("b2b.r7.write_reg", 32'(write_reg), 32'd1);
        checkOutput("b2b.r7.rn1_ex", 32'(rn1_ex), 32'd7);
        checkOutput("b2b.r7.write_r0", 32'(write_r0), 32'd1);
        checkOutput("b2b.r7.wb_r0_data", 32'(wb_r0_data), 32'h7070);
        applyStimulus(1'b1, 4'd0, 1'b1, 1'b0, 1'b0, 16'h0C0C, 16'h0000);
        stepClock();
        checkOutput("b2b.r0.write_reg", 32'(write_reg), 32'd1);
        checkOutput("b2b.r0.rn1_ex", 32'(rn1_ex), 32'd0);
        checkOutput("b2b.r0.write_r0", 32'(write_r0), 32'd0);
        checkOutput("b2b.r0.wb_data", 32'(wb_data), 32'h0C0C);
        checkOutput("b2b.stall", 32'(stall), 32'd0);

        // Async reset at count==2 drops stall without a clock edge.
        applyStimulus(1'b1, 4'd8, 1'b1, 1'b1, 1'b1, 16'h0000, 16'h0000);
        mc_result    = 16'h9999;
        mc_r0_result = 16'h6666;
        stepClock();
        applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        stepClock();
        checkOutput("arst.pre_stall", 32'(stall), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("arst.stall", 32'(stall), 32'd0);
        checkOutput("arst.rn1_ex", 32'(rn1_ex), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            stepClock();
            checkBubble($sformatf("arst.after%0d", i));
            checkOutput($sformatf("arst.stall_after%0d", i), 32'(stall), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
